// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, FSM state encoding, datapath mux codes
// and the one-hot instruction class layout used by the control unit.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [1:0] SRCA_RS1   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCA_ZERO  = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] WB_ALU     = 2'b00;
    localparam logic [1:0] WB_MEM     = 2'b01;
    localparam logic [1:0] WB_PC4     = 2'b10;

    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_ALU  = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    localparam int CLS_W       = 10;
    localparam int CLS_OP      = 0;
    localparam int CLS_OPIMM   = 1;
    localparam int CLS_LOAD    = 2;
    localparam int CLS_STORE   = 3;
    localparam int CLS_BRANCH  = 4;
    localparam int CLS_LUI     = 5;
    localparam int CLS_AUIPC   = 6;
    localparam int CLS_JAL     = 7;
    localparam int CLS_JALR    = 8;
    localparam int CLS_ILLEGAL = 9;

    typedef logic [CLS_W-1:0] instr_class_t;

endpackage

// File: rtl/instr_class_decoder.sv
// Combinational opcode classifier: maps IR[6:0] to a one-hot instruction class.
module instr_class_decoder
    import riscv_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output instr_class_t class_o
);

    // One-hot class lookup; anything unrecognised lands in ILLEGAL.
    always_comb begin
        class_o = '0;
        case (opcode_i)
            OPC_OP:     class_o[CLS_OP]      = 1'b1;
            OPC_OPIMM:  class_o[CLS_OPIMM]   = 1'b1;
            OPC_LOAD:   class_o[CLS_LOAD]    = 1'b1;
            OPC_STORE:  class_o[CLS_STORE]   = 1'b1;
            OPC_BRANCH: class_o[CLS_BRANCH]  = 1'b1;
            OPC_LUI:    class_o[CLS_LUI]     = 1'b1;
            OPC_AUIPC:  class_o[CLS_AUIPC]   = 1'b1;
            OPC_JAL:    class_o[CLS_JAL]     = 1'b1;
            OPC_JALR:   class_o[CLS_JALR]    = 1'b1;
            default:    class_o[CLS_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback over the shared datapath one instruction at a time.
module multicycle_control_unit
    import riscv_pkg::*;
#(
    parameter bit          TRAP_ON_ILLEGAL = 1'b1,
    parameter int unsigned MEM_WAIT_MAX    = 32'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       target_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       retired,
    output logic       trap
);

    localparam logic [15:0] WAIT_LIMIT = 16'(MEM_WAIT_MAX - 32'd1);

    state_e       state_q, state_d;
    instr_class_t class_q, class_d;
    instr_class_t cls_s;
    logic [15:0]  wait_q, wait_d;
    logic         waiting_s;
    logic         timeout_s;

    instr_class_decoder u_dec (
        .opcode_i (opcode),
        .class_o  (cls_s)
    );

    assign waiting_s = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign timeout_s = (MEM_WAIT_MAX != 32'd0) && waiting_s && (wait_q == WAIT_LIMIT);

    // State, latched class and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            class_q <= '0;
            wait_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
        end
    end

    // Class is captured once in DECODE so later states ignore the live opcode.
    always_comb begin
        class_d = class_q;
        if (state_q == S_DECODE) begin
            class_d = cls_s;
        end else begin
            class_d = class_q;
        end
    end

    // Consecutive stall counter; restarts on any handshake or state change.
    always_comb begin
        wait_d = 16'd0;
        if (waiting_s && (state_d == state_q)) begin
            if (wait_q != 16'hFFFF) begin
                wait_d = wait_q + 16'd1;
            end else begin
                wait_d = wait_q;
            end
        end else begin
            wait_d = 16'd0;
        end
    end

    // Next state and datapath controls; everything stays low while in reset.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        target_we = 1'b0;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        pc_write  = 1'b0;
        pc_src    = PCSRC_PC4;
        retired   = 1'b0;
        trap      = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout_s) begin
                        state_d = S_TRAP;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRCA_PC;
                    alu_src_b = SRCB_IMM;
                    target_we = 1'b1;
                    if (cls_s[CLS_ILLEGAL]) begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d = S_TRAP;
                        end else begin
                            pc_write = 1'b1;
                            retired  = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end else if (cls_s[CLS_JAL]) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    target_we = 1'b1;
                    if (class_q[CLS_OP]) begin
                        alu_op  = ALUOP_FUNC;
                        state_d = S_WB;
                    end else if (class_q[CLS_OPIMM]) begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALUOP_FUNC;
                        state_d   = S_WB;
                    end else if (class_q[CLS_LOAD] || class_q[CLS_STORE]) begin
                        alu_src_b = SRCB_IMM;
                        state_d   = S_MEM;
                    end else if (class_q[CLS_LUI]) begin
                        alu_src_a = SRCA_ZERO;
                        alu_src_b = SRCB_IMM;
                        state_d   = S_WB;
                    end else if (class_q[CLS_AUIPC]) begin
                        alu_src_a = SRCA_PC;
                        alu_src_b = SRCB_IMM;
                        state_d   = S_WB;
                    end else if (class_q[CLS_JALR]) begin
                        alu_src_b = SRCB_IMM;
                        state_d   = S_WB;
                    end else if (class_q[CLS_BRANCH]) begin
                        // Keep the DECODE-computed target in ALUOut for the taken path.
                        target_we = 1'b0;
                        alu_op    = ALUOP_SUB;
                        pc_write  = 1'b1;
                        pc_src    = br_taken ? PCSRC_ALU : PCSRC_PC4;
                        retired   = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        target_we = 1'b0;
                        state_d   = S_TRAP;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = class_q[CLS_STORE];
                    if (mem_ready) begin
                        if (class_q[CLS_LOAD]) begin
                            state_d = S_WB;
                        end else if (class_q[CLS_STORE]) begin
                            pc_write = 1'b1;
                            retired  = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d = S_TRAP;
                        end
                    end else if (timeout_s) begin
                        state_d = S_TRAP;
                    end else begin
                        state_d = S_MEM;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retired   = 1'b1;
                    if (class_q[CLS_LOAD]) begin
                        wb_sel = WB_MEM;
                    end else if (class_q[CLS_JAL] || class_q[CLS_JALR]) begin
                        wb_sel = WB_PC4;
                    end else begin
                        wb_sel = WB_ALU;
                    end
                    if (class_q[CLS_JAL]) begin
                        pc_src = PCSRC_ALU;
                    end else if (class_q[CLS_JALR]) begin
                        pc_src = PCSRC_JALR;
                    end else begin
                        pc_src = PCSRC_PC4;
                    end
                    state_d = S_FETCH;
                end
                S_TRAP: begin
                    trap    = 1'b1;
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_TRAP;
                end
            endcase
        end else begin
            state_d = S_FETCH;
        end
    end

endmodule
